// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-save compressor and the
// carry-propagate resolver of the GEMV accumulation path.
//   S_WIDTH : width of the redundant sum vector
//   C_WIDTH : width of the redundant carry vector (>= S_WIDTH)
//   R_WIDTH : width of the resolved binary total
//   SLICE   : bits resolved per pipeline stage
//   NSTAGE  : number of resolver stages, ceil(R_WIDTH / SLICE)
package csa_pkg;

  localparam int S_WIDTH = 22;
  localparam int C_WIDTH = 23;
  localparam int R_WIDTH = C_WIDTH + 1;
  localparam int SLICE   = 8;

  function automatic int calc_nstage(input int r_width, input int slice);
    return (r_width + slice - 1) / slice;
  endfunction

  localparam int NSTAGE = calc_nstage(R_WIDTH, SLICE);

  // Lowest result bit resolved by stage k.
  function automatic int slice_lo(input int k);
    return k * SLICE;
  endfunction

  // Bits resolved by stage k; only the top stage can be narrower than SLICE.
  function automatic int slice_width(input int k);
    int remaining;
    remaining = R_WIDTH - k * SLICE;
    return (remaining < SLICE) ? remaining : SLICE;
  endfunction

endpackage

// File: rtl/cpa_slice.sv
// Combinational W-bit ripple slice of the carry-propagate adder.
//   a, b : operand slices
//   cin  : carry from the previous slice
//   sum  : W-bit slice result
//   cout : carry into the next slice
module cpa_slice
  import csa_pkg::*;
#(
  parameter int W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-propagate resolver: turns the CSA sum/carry pair into a
// binary total, one SLICE-bit slice per stage with the carry registered
// between stages. Valid/ready on both sides with global-stall back-pressure.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = ~stall, combinational)
//   in_s, in_c          : redundant sum / carry vectors, unsigned
//   out_valid/out_ready : output handshake
//   out_sum             : registered in_s + in_c, exact
module csa_resolve_pipe
  import csa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [S_WIDTH-1:0] in_s,
  input  logic [C_WIDTH-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [R_WIDTH-1:0] out_sum
);

  // Skew registers keep operands shifted down so each stage always adds the
  // low bits of what it receives.
  localparam int SKEW_W = R_WIDTH - SLICE;

  logic              stall;
  logic              advance;
  logic [NSTAGE-1:0] valid_q;
  logic [R_WIDTH-1:0] res_q   [NSTAGE];
  logic [SKEW_W-1:0]  a_q     [NSTAGE-1];
  logic [SKEW_W-1:0]  b_q     [NSTAGE-1];
  logic               carry_q [NSTAGE-1];

  assign stall     = valid_q[NSTAGE-1] & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign out_valid = valid_q[NSTAGE-1];
  assign out_sum   = res_q[NSTAGE-1];

  // Bubbles shift along with real data; nothing is collapsed under stall.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q <= {valid_q[NSTAGE-2:0], in_valid};
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = slice_lo(k);
    localparam int W  = slice_width(k);

    logic [R_WIDTH-1:0] a_src;
    logic [R_WIDTH-1:0] b_src;
    logic [R_WIDTH-1:0] res_src;
    logic [R_WIDTH-1:0] res_nxt;
    logic               cin;
    logic               src_valid;
    logic [W-1:0]       sum;
    logic               cout;

    if (k == 0) begin : g_first
      assign a_src     = R_WIDTH'(in_s);
      assign b_src     = R_WIDTH'(in_c);
      assign res_src   = '0;
      assign cin       = 1'b0;
      assign src_valid = in_valid;
    end else begin : g_rest
      assign a_src     = {{SLICE{1'b0}}, a_q[k-1]};
      assign b_src     = {{SLICE{1'b0}}, b_q[k-1]};
      assign res_src   = res_q[k-1];
      assign cin       = carry_q[k-1];
      assign src_valid = valid_q[k-1];
    end

    cpa_slice #(.W(W)) u_slice (
      .a   (a_src[W-1:0]),
      .b   (b_src[W-1:0]),
      .cin (cin),
      .sum (sum),
      .cout(cout)
    );

    // NOTE: the default copy comes first so every bit is assigned on every
    // pass and no latch is inferred.
    always_comb begin
      res_nxt          = res_src;
      res_nxt[LO +: W] = sum;
    end

    // Data only moves with a valid token, so bubbles leave the last result
    // in place instead of loading whatever sits on the bus.
    // NOTE: data registers are reset too, so out_sum reads 0 after reset
    // and no stale partial result survives a mid-stream reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_q[k] <= '0;
      end else if (advance && src_valid) begin
        res_q[k] <= res_nxt;
      end
    end

    if (k < NSTAGE - 1) begin : g_skew
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q[k]     <= '0;
          b_q[k]     <= '0;
          carry_q[k] <= 1'b0;
        end else if (advance && src_valid) begin
          a_q[k]     <= a_src[R_WIDTH-1:SLICE];
          b_q[k]     <= b_src[R_WIDTH-1:SLICE];
          carry_q[k] <= cout;
        end
      end
    end else begin : g_top
      // The top slice consumes the last operand bits; its carry-out is
      // always 0 because the total fits in R_WIDTH bits.
      logic [R_WIDTH-W-1:0] unused_a_hi;
      logic [R_WIDTH-W-1:0] unused_b_hi;
      logic                 unused_cout;
      assign unused_a_hi = a_src[R_WIDTH-1:W];
      assign unused_b_hi = b_src[R_WIDTH-1:W];
      assign unused_cout = cout;
    end
  end

endmodule

// File: tb/tb_csa_resolve_pipe.sv
module tb_csa_resolve_pipe;
  import csa_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [S_WIDTH-1:0] in_s;
  logic [C_WIDTH-1:0] in_c;
  logic               out_valid;
  logic               out_ready;
  logic [R_WIDTH-1:0] out_sum;

  csa_resolve_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_s     (in_s),
    .in_c     (in_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a token occupies one of NSTAGE positions and moves one
  // position per non-stalled edge; its value is plain in_s + in_c.
  bit                 tok_v   [NSTAGE];
  logic [R_WIDTH-1:0] tok_sum [NSTAGE];
  logic [R_WIDTH-1:0] order_q [$];
  int                 cyc;
  int                 last_out_cyc;
  logic [R_WIDTH-1:0] last_out;

  function automatic logic [R_WIDTH-1:0] ref_sum(input logic [S_WIDTH-1:0] s,
                                                  input logic [C_WIDTH-1:0] c);
    return R_WIDTH'(s) + R_WIDTH'(c);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSTAGE; i++) begin
      tok_v[i]   = 1'b0;
      tok_sum[i] = '0;
    end
    order_q.delete();
  endtask

  // Called just after a falling edge with inputs already driven; checks the
  // cycle, updates the model and returns after the next falling edge.
  task automatic cycle();
    bit exp_stall;
    #1;
    exp_stall = tok_v[NSTAGE-1] && !out_ready;
    check("in_ready", in_ready, !exp_stall);
    check("out_valid", out_valid, tok_v[NSTAGE-1]);
    if (tok_v[NSTAGE-1]) check("out_sum", out_sum, tok_sum[NSTAGE-1]);
    if (tok_v[NSTAGE-1] && out_ready) begin
      if (order_q.size() == 0) check("order_underrun", 1, 0);
      else check("order", out_sum, order_q.pop_front());
      last_out     = out_sum;
      last_out_cyc = cyc;
    end
    if (!exp_stall) begin
      if (in_valid) order_q.push_back(ref_sum(in_s, in_c));
      for (int i = NSTAGE - 1; i > 0; i--) begin
        tok_v[i]   = tok_v[i-1];
        tok_sum[i] = tok_sum[i-1];
      end
      tok_v[0]   = in_valid;
      tok_sum[0] = ref_sum(in_s, in_c);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic single_op(input string tag, input logic [S_WIDTH-1:0] s,
                           input logic [C_WIDTH-1:0] c, input logic [R_WIDTH-1:0] exp);
    int acc_cyc;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_s         = s;
    in_c         = c;
    acc_cyc      = cyc;
    last_out_cyc = -1;
    cycle();
    idle(NSTAGE + 2);
    check({tag, "_sum"}, last_out, exp);
    check({tag, "_latency"}, 64'(last_out_cyc - acc_cyc), 64'(NSTAGE));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_s      = '0;
    in_c      = '0;
    out_ready = 1'b1;
    cyc       = 0;
    last_out  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    rst = 1'b0;

    // Idle after reset release: nothing valid, result bus still zero.
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("idle_sum", out_sum, 0);
    end

    single_op("max", 22'h3FFFFF, 23'h7FFFFE, 24'hBFFFFD);
    single_op("ripple", 22'h0000FF, 23'h7FFF01, 24'h800000);
    single_op("cin_bit0", 22'h000001, 23'h000001, 24'h000002);

    // Back-to-back random stream, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_s     = S_WIDTH'($urandom);
      in_c     = C_WIDTH'($urandom);
      cycle();
    end
    idle(NSTAGE + 1);
    check("stream_drained", order_q.size(), 0);

    // Back-pressure: 4 ops, then hold the consumer off for 5 cycles while
    // offering junk inputs that must be ignored.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_s     = S_WIDTH'($urandom);
      in_c     = C_WIDTH'($urandom);
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_s     = S_WIDTH'($urandom);
      in_c     = C_WIDTH'($urandom);
      cycle();
    end
    out_ready = 1'b1;
    idle(NSTAGE + 2);
    check("bp_drained", order_q.size(), 0);

    // Random valid/ready mix.
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_s      = S_WIDTH'($urandom);
      in_c      = C_WIDTH'($urandom);
      cycle();
    end
    out_ready = 1'b1;
    idle(NSTAGE + 2);
    check("mix_drained", order_q.size(), 0);

    // Asynchronous reset with 3 ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_s     = S_WIDTH'($urandom);
      in_c     = C_WIDTH'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_sum", out_sum, 0);
    check("async_rst_in_ready", in_ready, 1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    idle(NSTAGE + 1);
    single_op("post_reset", 22'h12345, 23'h54321, 24'h066666);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
